// File: rtl/fsm_sens_universal.sv
// Universal N-state sequencer kernel with binary state codes.
// A run-time transition table gives, for every state, the target taken on an
// advance. The block also provides synchronous force-load, a state-entry
// pulse, a previous-state register, a saturating dwell counter and a sticky
// flag for requests that name a state code outside 0..NS-1.
// Every output is a register, so there is no combinational input-to-output path.
module fsm_sens_universal #(
  parameter int NS     = 8,
  parameter int CW     = 16,
  parameter int RST_ST = 0,
  localparam int SW    = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NS*SW-1:0]  tx,
  input  logic              frc,
  input  logic [SW-1:0]     frc_st,
  output logic [SW-1:0]     st,
  output logic [SW-1:0]     st_prev,
  output logic              entry,
  output logic [CW-1:0]     dwell,
  output logic              illegal
);

  // Outcome of one edge: move to a new state, flag a bad request, or stay put.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_ENTER = 2'd1,
    ACT_FLAG  = 2'd2
  } act_e;

  // Registered state and status.
  logic [SW-1:0] st_p0;
  logic [SW-1:0] st_prev_p0;
  logic          entry_p0;
  logic [CW-1:0] dwell_p0;
  logic          illegal_p0;

  // Decode of the current cycle.
  logic [SW-1:0] tgt;
  logic [SW-1:0] nxt;
  act_e          act;

  // Dwell counter increment that sticks at the all-ones value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // A code is usable only if it names one of the NS real states; when NS is
  // not a power of two the upper codes of the SW-bit field are unreachable.
  function automatic logic in_range(input logic [SW-1:0] code);
    return 32'(code) < NS;
  endfunction

  // Table lookup: only the NS populated entries are decoded, indexed by the
  // registered state (which never holds an out-of-range code).
  always_comb begin
    tgt = '0;
    for (int i = 0; i < NS; i++) begin
      if (st_p0 == SW'(i)) begin
        tgt = tx[i*SW +: SW];
      end
    end
  end

  // Next-state decision, priority frc > en > hold. A force re-enters even the
  // current state; an advance to the current state is a silent self-loop.
  always_comb begin
    act = ACT_HOLD;
    nxt = st_p0;
    if (frc) begin
      if (in_range(frc_st)) begin
        act = ACT_ENTER;
        nxt = frc_st;
      end else begin
        act = ACT_FLAG;
      end
    end else if (en) begin
      if (!in_range(tgt)) begin
        act = ACT_FLAG;
      end else if (tgt != st_p0) begin
        act = ACT_ENTER;
        nxt = tgt;
      end
    end
  end

  // ---- stage p0: state, history, entry pulse, dwell and sticky flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      st_p0      <= SW'(RST_ST);
      st_prev_p0 <= SW'(RST_ST);
      entry_p0   <= 1'b0;
      dwell_p0   <= '0;
      illegal_p0 <= 1'b0;
    end else begin
      case (act)
        ACT_ENTER: begin
          st_p0      <= nxt;
          st_prev_p0 <= st_p0;
          entry_p0   <= 1'b1;
          dwell_p0   <= '0;
        end
        ACT_FLAG: begin
          illegal_p0 <= 1'b1;
          entry_p0   <= 1'b0;
          dwell_p0   <= sat_inc(dwell_p0);
        end
        default: begin
          entry_p0   <= 1'b0;
          dwell_p0   <= sat_inc(dwell_p0);
        end
      endcase
    end
  end

  assign st      = st_p0;
  assign st_prev = st_prev_p0;
  assign entry   = entry_p0;
  assign dwell   = dwell_p0;
  assign illegal = illegal_p0;

endmodule

// File: tb/tb_fsm_sens_universal.sv
// Bench for fsm_sens_universal: instance A (NS=8, CW=16, RST_ST=3) and
// instance B (NS=6, CW=3, RST_ST=0) run side by side against a behavioural
// model, with a vector table, directed corner sequences and random stimulus.
module tb_fsm_sens_universal;

  localparam int NS_A = 8;
  localparam int CW_A = 16;
  localparam int RS_A = 3;
  localparam int NS_B = 6;
  localparam int CW_B = 3;
  localparam int RS_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A signals
  logic              rst_a, en_a, frc_a;
  logic [NS_A*3-1:0] tx_a;
  logic [2:0]        frc_st_a, st_a, st_prev_a;
  logic              entry_a, illegal_a;
  logic [CW_A-1:0]   dwell_a;

  // instance B signals
  logic              rst_b, en_b, frc_b;
  logic [NS_B*3-1:0] tx_b;
  logic [2:0]        frc_st_b, st_b, st_prev_b;
  logic              entry_b, illegal_b;
  logic [CW_B-1:0]   dwell_b;

  fsm_sens_universal #(.NS(NS_A), .CW(CW_A), .RST_ST(RS_A)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .tx(tx_a), .frc(frc_a), .frc_st(frc_st_a),
    .st(st_a), .st_prev(st_prev_a), .entry(entry_a), .dwell(dwell_a), .illegal(illegal_a)
  );

  fsm_sens_universal #(.NS(NS_B), .CW(CW_B), .RST_ST(RS_B)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .tx(tx_b), .frc(frc_b), .frc_st(frc_st_b),
    .st(st_b), .st_prev(st_prev_b), .entry(entry_b), .dwell(dwell_b), .illegal(illegal_b)
  );

  // Behavioural model state.
  typedef struct {
    int st;
    int prev;
    int entry;
    int dwell;
    int ill;
  } mst_t;

  typedef struct {
    int rst; int en; int frc; int fs;
    int st; int prev; int ent; int dw; int ill;
  } vec_t;

  int   ta  [8];
  int   tbv [8];
  mst_t m_a, m_b;
  int   checks = 0;
  int   errors = 0;
  vec_t vt [12];

  // One edge of the sequencer, written from its rules.
  function automatic mst_t step(input mst_t m, input int ns, input int cw, input int rs,
                                input int r, input int e, input int f, input int fs,
                                input int t);
    mst_t n;
    int   target;
    int   maxd;
    n      = m;
    maxd   = (1 << cw) - 1;
    target = -1;
    if (r != 0) begin
      n.st = rs; n.prev = rs; n.entry = 0; n.dwell = 0; n.ill = 0;
      return n;
    end
    if (f != 0) begin
      if (fs < ns) target = fs;
      else n.ill = 1;
    end else if (e != 0) begin
      if (t >= ns) n.ill = 1;
      else if (t != m.st) target = t;
    end
    if (target >= 0) begin
      n.prev = m.st; n.st = target; n.entry = 1; n.dwell = 0;
    end else begin
      n.entry = 0;
      n.dwell = (m.dwell + 1 > maxd) ? maxd : m.dwell + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NS_A; i++) tx_a[i*3 +: 3] = 3'(ta[i]);
    for (int i = 0; i < NS_B; i++) tx_b[i*3 +: 3] = 3'(tbv[i]);
  endtask

  // Apply current inputs across one edge, advance the model, compare both DUTs.
  task automatic tick();
    pack();
    @(posedge clk);
    m_a = step(m_a, NS_A, CW_A, RS_A, int'(rst_a), int'(en_a), int'(frc_a),
               int'(frc_st_a), ta[m_a.st]);
    m_b = step(m_b, NS_B, CW_B, RS_B, int'(rst_b), int'(en_b), int'(frc_b),
               int'(frc_st_b), tbv[m_b.st]);
    #1;
    chk("A_st", int'(st_a), m_a.st);
    chk("A_prev", int'(st_prev_a), m_a.prev);
    chk("A_entry", int'(entry_a), m_a.entry);
    chk("A_dwell", int'(dwell_a), m_a.dwell);
    chk("A_illegal", int'(illegal_a), m_a.ill);
    chk("B_st", int'(st_b), m_b.st);
    chk("B_prev", int'(st_prev_b), m_b.prev);
    chk("B_entry", int'(entry_b), m_b.entry);
    chk("B_dwell", int'(dwell_b), m_b.dwell);
    chk("B_illegal", int'(illegal_b), m_b.ill);
  endtask

  task automatic quiet();
    rst_a = 1'b0; en_a = 1'b0; frc_a = 1'b0; frc_st_a = 3'd0;
    rst_b = 1'b0; en_b = 1'b0; frc_b = 1'b0; frc_st_b = 3'd0;
  endtask

  initial begin
    quiet();
    m_a = '{0, 0, 0, 0, 0};
    m_b = '{0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      ta[i]  = (i + 1) % 8;
      tbv[i] = (i + 1) % 6;
    end

    // Vector table for A with tx[y]=(y+1)%8: {rst,en,frc,fs, st,prev,entry,dwell,illegal}
    vt[0]  = '{1, 0, 0, 0, 3, 3, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 3, 3, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 3, 3, 0, 1, 0};
    vt[3]  = '{0, 1, 0, 0, 4, 3, 1, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 5, 4, 1, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 5, 4, 0, 1, 0};
    vt[6]  = '{0, 1, 1, 5, 5, 5, 1, 0, 0};
    vt[7]  = '{0, 1, 1, 1, 1, 5, 1, 0, 0};
    vt[8]  = '{0, 1, 0, 0, 2, 1, 1, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 2, 1, 0, 1, 0};
    vt[10] = '{0, 0, 0, 0, 2, 1, 0, 2, 0};
    vt[11] = '{1, 1, 1, 6, 3, 3, 0, 0, 0};

    for (int k = 0; k < 12; k++) begin
      rst_a = vt[k].rst[0]; en_a = vt[k].en[0]; frc_a = vt[k].frc[0];
      frc_st_a = 3'(vt[k].fs);
      rst_b = vt[k].rst[0]; en_b = 1'b0; frc_b = 1'b0;
      tick();
      chk("vec_st", int'(st_a), vt[k].st);
      chk("vec_prev", int'(st_prev_a), vt[k].prev);
      chk("vec_entry", int'(entry_a), vt[k].ent);
      chk("vec_dwell", int'(dwell_a), vt[k].dw);
      chk("vec_illegal", int'(illegal_a), vt[k].ill);
    end

    // Walk through all eight states of A starting from 0.
    quiet();
    frc_a = 1'b1; frc_st_a = 3'd0;
    tick();
    frc_a = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("walk_st", int'(st_a), k % 8);
      chk("walk_prev", int'(st_prev_a), (k + 7) % 8);
      chk("walk_entry", int'(entry_a), 1);
      chk("walk_dwell", int'(dwell_a), 0);
    end

    // Self-loop on B in state 2; dwell saturates at 7 with CW=3.
    quiet();
    tbv[2] = 2;
    frc_b = 1'b1; frc_st_b = 3'd2;
    tick();
    frc_b = 1'b0; en_b = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("loop_st", int'(st_b), 2);
      chk("loop_entry", int'(entry_b), 0);
      chk("loop_dwell", int'(dwell_b), (k > 7) ? 7 : k);
    end
    tbv[2] = 3;

    // Force beats advance; forcing the same state re-enters it.
    quiet();
    frc_a = 1'b1; frc_st_a = 3'd5;
    tick();
    ta[5] = 6; en_a = 1'b1; frc_st_a = 3'd1;
    tick();
    chk("frc_st", int'(st_a), 1);
    chk("frc_prev", int'(st_prev_a), 5);
    chk("frc_entry", int'(entry_a), 1);
    tick();
    chk("frc2_st", int'(st_a), 1);
    chk("frc2_entry", int'(entry_a), 1);
    chk("frc2_dwell", int'(dwell_a), 0);

    // Out-of-range targets on B set the sticky flag; only rst clears it.
    quiet();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0; tbv[0] = 7; en_b = 1'b1;
    tick();
    chk("ill_st", int'(st_b), 0);
    chk("ill_flag", int'(illegal_b), 1);
    en_b = 1'b0; frc_b = 1'b1; frc_st_b = 3'd6;
    tick();
    chk("ill_frc_st", int'(st_b), 0);
    chk("ill_frc_flag", int'(illegal_b), 1);
    chk("ill_frc_entry", int'(entry_b), 0);
    frc_b = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("ill_sticky", int'(illegal_b), 1);
    rst_b = 1'b1;
    tick();
    chk("ill_clear", int'(illegal_b), 0);
    tbv[0] = 1;

    // Reset mid-run overrides a simultaneous force.
    quiet();
    frc_a = 1'b1; frc_st_a = 3'd4;
    tick();
    frc_a = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("mid_dwell", int'(dwell_a), 9);
    rst_a = 1'b1; frc_a = 1'b1; en_a = 1'b1; frc_st_a = 3'd1;
    tick();
    chk("mid_st", int'(st_a), RS_A);
    chk("mid_dwell0", int'(dwell_a), 0);
    chk("mid_entry", int'(entry_a), 0);

    // Random stimulus against the model.
    quiet();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 4) == 0) ta[$urandom_range(0, 7)] = $urandom_range(0, 7);
      if ($urandom_range(0, 4) == 0) tbv[$urandom_range(0, 5)] = $urandom_range(0, 7);
      rst_a    = ($urandom_range(0, 59) == 0);
      frc_a    = ($urandom_range(0, 7) == 0);
      frc_st_a = 3'($urandom_range(0, 7));
      en_a     = ($urandom_range(0, 1) == 0);
      rst_b    = ($urandom_range(0, 79) == 0);
      frc_b    = ($urandom_range(0, 9) == 0);
      frc_st_b = 3'($urandom_range(0, 7));
      en_b     = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
